// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA
// display fetch (reads, always win) and the image writer (writes, take the
// leftover cycles). Also tracks per-frame accepted-write counts and a sticky
// writer starvation flag.
//
// Optional build macro: VGA_FB_WR_BLANK_ONLY_EN
//   defined   -> writes are only accepted while blank=1 (tear-free updates)
//   undefined -> writes may use any cycle the display does not claim
//
// Handshake: a write transfers on a clock edge where wr_valid=1 and
// wr_ready=1; wr_ready is combinational and may be high with wr_valid=0.
// disp_req has no backpressure: every cycle it is high is a granted read
// returning exactly one disp_valid pulse, in request order.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              blank,
  input  logic              frame_start,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_starved,
  output logic [ADDR_W:0]   wr_count_last
);

  // One stage where the request registers onto mem_*, one where the RAM
  // samples it, RD_LAT RAM stages; disp_valid is registered after the last.
  localparam int PIPE_D   = RD_LAT + 2;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_PRE = STARVE_W'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

  gnt_t                gnt;
  logic                gate;
  logic                stall;
  logic                accept;
  logic [PIPE_D-1:0]   rd_pipe;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W:0]     wr_count;

`ifdef VGA_FB_WR_BLANK_ONLY_EN
  assign gate = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign gate = 1'b1;
`endif

  // Per-cycle grant decision: display first, writer only when gated in.
  always_comb begin
    wr_ready = !rst && !disp_req && gate;
    gnt      = GNT_IDLE;
    if (disp_req) begin
      gnt = GNT_RD;
    end else if (wr_valid && wr_ready) begin
      gnt = GNT_WR;
    end
    accept = (gnt == GNT_WR);
    stall  = wr_valid && !wr_ready;
  end

  // Register the grant onto the RAM port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (gnt)
        GNT_RD: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        GNT_WR: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Track granted reads through the RAM latency and capture their data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe    <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_pipe    <= {rd_pipe[PIPE_D-2:0], disp_req};
      disp_valid <= rd_pipe[PIPE_D-1];
      if (rd_pipe[PIPE_D-1]) begin
        disp_data <= mem_rdata;
      end
    end
  end

  // Count consecutive stalled writer cycles; latch starvation when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else if (stall) begin
      if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (starve_cnt >= STARVE_PRE) begin
        wr_starved <= 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Per-frame accepted-write count; a write on frame_start opens the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count      <= '0;
      wr_count_last <= '0;
    end else if (frame_start) begin
      wr_count_last <= wr_count;
      wr_count      <= {{ADDR_W{1'b0}}, accept};
    end else if (accept && !(&wr_count)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

endmodule
